// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op encodings and
// packed views of the stage buses.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 39;

  typedef enum logic [2:0] {
    LOAD_OP_W  = 3'd0,
    LOAD_OP_B  = 3'd1,
    LOAD_OP_H  = 3'd2,
    LOAD_OP_BU = 3'd3,
    LOAD_OP_HU = 3'd4
  } load_op_e;

  // exe -> mem bus; load_op is left as a raw code so unknown encodings survive
  typedef struct packed {
    logic        res_from_mem;
    logic        mem_req;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        fwd_we;
    logic        result_pending;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_to_ds_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it. Purely combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the byte and halfword addressed by the low address bits
  always_comb begin
    byte_sel = raw[7:0];
    case (offset)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
  end

  // Extend according to the load kind; unknown codes behave as a word load
  always_comb begin
    data = raw;
    case (load_op)
      LOAD_OP_B:  data = ext8(byte_sel, 1'b1);
      LOAD_OP_BU: data = ext8(byte_sel, 1'b0);
      LOAD_OP_H:  data = ext16(half_sel, 1'b1);
      LOAD_OP_HU: data = ext16(half_sel, 1'b0);
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the five-stage LoongArch32 pipeline. Holds one instruction,
// waits for the data-SRAM response on memory ops, buffers it under
// write-back backpressure, aligns load data and forwards results to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  logic        ms_valid;
  es_to_ms_t   ms_bus;
  logic        rdata_buf_valid;
  logic [31:0] rdata_buf;

  logic        data_ok_take;
  logic        ms_ready_go;
  logic        ms_leave;
  logic [31:0] raw;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        fwd_we;
  ms_to_ws_t   ws_out;
  ms_to_ds_t   ds_out;

  // Handshake and response acceptance
  always_comb begin
    data_ok_take   = ms_valid && ms_bus.mem_req && !rdata_buf_valid && data_sram_data_ok;
    ms_ready_go    = !ms_bus.mem_req || data_ok_take || rdata_buf_valid;
    ms_to_ws_valid = ms_valid && ms_ready_go;
    ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    ms_leave       = ms_to_ws_valid && ws_allowin;
  end

  // Stage valid bit: refilled whenever the stage can accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction payload capture; contents are don't-care while invalid
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  // Response buffer: holds data_ok data while write-back is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
    end else if (ms_leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (data_ok_take && !ws_allowin) begin
      rdata_buf_valid <= 1'b1;
    end
  end

  // Buffer data register; captured alongside the valid flag
  always_ff @(posedge clk) begin
    if (data_ok_take && !ws_allowin) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign raw = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .raw     (raw),
    .offset  (ms_bus.alu_result[1:0]),
    .load_op (ms_bus.load_op),
    .data    (load_data)
  );

  // Result selection and outgoing buses
  always_comb begin
    final_result = ms_bus.res_from_mem ? load_data : ms_bus.alu_result;
    fwd_we       = ms_valid && ms_bus.gr_we && (ms_bus.dest != 5'd0);

    ws_out              = '0;
    ws_out.gr_we        = ms_bus.gr_we;
    ws_out.dest         = ms_bus.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = ms_bus.pc;

    ds_out                = '0;
    ds_out.fwd_we         = fwd_we;
    ds_out.result_pending = fwd_we && ms_bus.res_from_mem && !ms_ready_go;
    ds_out.dest           = ms_bus.dest;
    ds_out.result         = final_result;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_to_ds_bus = ds_out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of load alignment vectors,
// directed multi-cycle sequences and a randomized run against an
// instruction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_ok;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  typedef struct packed {
    logic        res_from_mem;
    logic        mem_req;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    ws_allowin     = 1'b1;
    data_ok        = 1'b0;
    rdata          = '0;
  endtask

  function automatic logic [74:0] mk(input logic rfm, input logic mreq, input logic [2:0] op,
                                     input logic we, input logic [4:0] dst,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {rfm, mreq, op, we, dst, alu, pc};
  endfunction

  // Load semantics from the instruction definitions: shift the addressed
  // unit down, then extend
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * off);
    h = w >> (16 * off[1]);
    case (op)
      3'd1: return {{24{b[7]}}, b[7:0]};
      3'd3: return {24'd0, b[7:0]};
      3'd2: return {{16{h[15]}}, h[15:0]};
      3'd4: return {16'd0, h[15:0]};
      default: return w;
    endcase
  endfunction

  // reference model state
  ins_t        m;
  logic        m_valid;
  logic        m_got;
  logic [31:0] m_data;

  initial begin
    ins_t        ins;
    logic [95:0] r;
    logic        acc, rg, e_valid, e_allow, fwd, pend;
    logic [31:0] fr;

    vecs[0]  = '{3'd0, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[1]  = '{3'd1, 2'd0, 32'h80FF7F01, 32'h00000001};
    vecs[2]  = '{3'd1, 2'd1, 32'h80FF7F01, 32'h0000007F};
    vecs[3]  = '{3'd1, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
    vecs[4]  = '{3'd1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[5]  = '{3'd3, 2'd2, 32'h80FF7F01, 32'h000000FF};
    vecs[6]  = '{3'd3, 2'd3, 32'h80FF7F01, 32'h00000080};
    vecs[7]  = '{3'd2, 2'd0, 32'h80FF7F01, 32'h00007F01};
    vecs[8]  = '{3'd2, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[9]  = '{3'd2, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[10] = '{3'd4, 2'd2, 32'h80FF7F01, 32'h000080FF};
    vecs[11] = '{3'd4, 2'd1, 32'h80FF7F01, 32'h00007F01};
    vecs[12] = '{3'd5, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
    vecs[13] = '{3'd7, 2'd3, 32'h80FF7F01, 32'h80FF7F01};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_ws_valid", ms_to_ws_valid, 1'b0);
    chk("reset_allowin", ms_allowin, 1'b1);
    chk("reset_fwd_bits", ms_to_ds_bus[38:37], 2'b00);

    // ALU op, no stall
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h1234, 32'h1c000000);
    tick();
    idle();
    #1;
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h1c000000});
    chk("alu_fwd", ms_to_ds_bus, {1'b1, 1'b0, 5'd5, 32'h1234});
    tick();
    chk("alu_drained", ms_to_ws_valid, 1'b0);

    // alignment table: each load gets its response one cycle after entry
    for (int i = 0; i < 14; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, vecs[i].op, 1'b1, 5'd3,
                          {30'h1000, vecs[i].off}, 32'h1c000100 + i * 4);
      tick();
      es_to_ms_valid = 1'b0;
      data_ok        = 1'b1;
      rdata          = vecs[i].rd;
      #1;
      chk("align_valid", ms_to_ws_valid, 1'b1);
      chk("align_result", ms_to_ws_bus[63:32], vecs[i].exp);
      tick();
      data_ok = 1'b0;
    end

    // LD.B with delayed response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 1'b1, 3'd1, 1'b1, 5'd7, 32'h00000003, 32'h1c000200);
    tick();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rdata = 32'h12345678;
      #1;
      chk("ldb_pending", ms_to_ds_bus[38:37], 2'b11);
      chk("ldb_allowin", ms_allowin, 1'b0);
      chk("ldb_not_valid", ms_to_ws_valid, 1'b0);
      tick();
    end
    data_ok = 1'b1;
    rdata   = 32'h80FF0000;
    #1;
    chk("ldb_valid", ms_to_ws_valid, 1'b1);
    chk("ldb_result", ms_to_ws_bus[63:32], 32'hFFFFFF80);
    chk("ldb_fwd", ms_to_ds_bus, {1'b1, 1'b0, 5'd7, 32'hFFFFFF80});
    chk("ldb_allowin_go", ms_allowin, 1'b1);
    tick();
    idle();

    // LD.HU with backpressure at the response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 1'b1, 3'd4, 1'b1, 5'd9, 32'h00000002, 32'h1c000300);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin     = 1'b0;
    data_ok        = 1'b1;
    rdata          = 32'hABCD1234;
    #1;
    chk("lhu_offer", ms_to_ws_valid, 1'b1);
    chk("lhu_stall", ms_allowin, 1'b0);
    tick();
    data_ok = 1'b0;
    rdata   = 32'h55555555;
    #1;
    chk("lhu_buf_valid", ms_to_ws_valid, 1'b1);
    chk("lhu_buf_result", ms_to_ws_bus[63:32], 32'h0000ABCD);
    tick();
    ws_allowin = 1'b1;
    #1;
    chk("lhu_release", {ms_to_ws_valid, ms_allowin}, 2'b11);
    chk("lhu_release_result", ms_to_ws_bus[63:32], 32'h0000ABCD);
    tick();
    chk("lhu_drained", ms_to_ws_valid, 1'b0);

    // Store waits for its response, never forwards
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 1'b1, 3'd0, 1'b0, 5'd4, 32'h00000100, 32'h1c000400);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("st_wait", {ms_to_ws_valid, ms_allowin, ms_to_ds_bus[38]}, 3'b000);
    tick();
    data_ok = 1'b1;
    #1;
    chk("st_valid", ms_to_ws_valid, 1'b1);
    chk("st_gr_we", ms_to_ws_bus[69], 1'b0);
    chk("st_fwd", ms_to_ds_bus[38], 1'b0);
    tick();
    idle();

    // Back-to-back ALU ops
    for (int k = 0; k < 3; k++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b0, 1'b0, 3'd0, 1'b1, 5'(k + 1), 32'h100 + k, 32'h1c000500 + k * 4);
      tick();
      chk("b2b_valid", ms_to_ws_valid, 1'b1);
      chk("b2b_pc", ms_to_ws_bus[31:0], 32'h1c000500 + k * 4);
    end
    es_to_ms_valid = 1'b0;
    tick();
    chk("b2b_end", ms_to_ws_valid, 1'b0);

    // Reset while a load waits, then a stray response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'h00000010, 32'h1c000600);
    tick();
    es_to_ms_valid = 1'b0;
    reset          = 1'b1;
    tick();
    reset   = 1'b0;
    data_ok = 1'b1;
    rdata   = 32'hDEADBEEF;
    #1;
    chk("rst_stray_valid", ms_to_ws_valid, 1'b0);
    chk("rst_stray_allowin", ms_allowin, 1'b1);
    chk("rst_stray_fwd", ms_to_ds_bus[38:37], 2'b00);
    tick();
    data_ok        = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'h00000020, 32'h1c000700);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("rst_no_stale_buf", ms_to_ws_valid, 1'b0);
    data_ok = 1'b1;
    rdata   = 32'hCAFEF00D;
    #1;
    chk("rst_new_load", ms_to_ws_bus[63:32], 32'hCAFEF00D);
    tick();
    idle();

    // Randomized run against the instruction-level model
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    m       = '0;
    m_valid = 1'b0;
    m_got   = 1'b0;
    m_data  = '0;
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom, $urandom, $urandom};
      ins = r[74:0];
      ins.mem_req = ins.res_from_mem | ins.mem_req;
      es_to_ms_valid = ($urandom_range(0, 3) != 0);
      es_to_ms_bus   = ins;
      ws_allowin     = ($urandom_range(0, 3) != 0);
      data_ok        = ($urandom_range(0, 2) == 0);
      rdata          = $urandom;
      #1;
      acc     = m_valid && m.mem_req && !m_got && data_ok;
      rg      = !m.mem_req || acc || m_got;
      fr      = m.res_from_mem ? ref_load(m.load_op, m.alu[1:0], m_got ? m_data : rdata) : m.alu;
      e_valid = m_valid && rg;
      e_allow = !m_valid || (rg && ws_allowin);
      fwd     = m_valid && m.gr_we && (m.dest != 5'd0);
      pend    = fwd && m.res_from_mem && !rg;
      chk("rnd_allowin", ms_allowin, e_allow);
      chk("rnd_valid", ms_to_ws_valid, e_valid);
      chk("rnd_fwd_bits", ms_to_ds_bus[38:37], {fwd, pend});
      if (e_valid) chk("rnd_ws_bus", ms_to_ws_bus, {m.gr_we, m.dest, fr, m.pc});
      if (fwd) chk("rnd_fwd_data", ms_to_ds_bus[36:0], {m.dest, fr});
      @(posedge clk);
      if (m_valid) begin
        if (rg && ws_allowin) m_got = 1'b0;
        else if (acc) begin
          m_got  = 1'b1;
          m_data = rdata;
        end
      end
      if (e_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m     = ins;
          m_got = 1'b0;
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
